// File: rtl/adxl345_spi_responder.sv
// ---------------------------------------------------------------------------
// adxl345_spi_responder
//
// SPI target (mode 3, MSB first) that mimics the register interface of an
// ADXL345 accelerometer. All SPI inputs are oversampled by the system clock
// through SYNC_STAGES-deep synchronizers; edges are detected in the clk
// domain, so spi_clk must run at clk/8 or slower.
//
// Build option:
//   ADXL_RESP_WRITE_EN  defined   -> write transactions update the writable
//                                    registers and pulse wr_pulse.
//                       undefined -> writes are ignored, wr_pulse stays 0 and
//                                    writable registers keep reset values.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   spi_clk        SPI clock from the initiator (idles high)
//   CS             chip select, active-low
//   MOSI / MISO    serial data in / out
//   x_data, y_data, z_data   axis samples, snapshotted at CS falling edge
//   power_ctl      register 0x2D
//   data_format    register 0x31
//   bw_rate        register 0x2C
//   wr_pulse       one-cycle strobe when a write byte is committed
//   wr_addr        address of the most recent committed write
//   xfer_active    high between detected CS fall and detected CS rise
// ---------------------------------------------------------------------------
module adxl345_spi_responder #(
    parameter logic [7:0] DEVID       = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [15:0] x_data,
    input  logic [15:0] y_data,
    input  logic [15:0] z_data,
    output logic [7:0]  power_ctl,
    output logic [7:0]  data_format,
    output logic [7:0]  bw_rate,
    output logic        wr_pulse,
    output logic [5:0]  wr_addr,
    output logic        xfer_active
);

`ifdef ADXL_RESP_WRITE_EN
    localparam bit WRITE_EN = 1'b1;
`else
    localparam bit WRITE_EN = 1'b0;
`endif

    // Depths below 2 are not metastability-safe; clamp to 2.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CMD     = 2'd1,
        S_DATA    = 2'd2,
        S_WAIT_CS = 2'd3
    } state_t;

    function automatic logic is_writable(input logic [5:0] a);
        return ((a >= 6'h1D) && (a <= 6'h2A)) ||
               ((a >= 6'h2C) && (a <= 6'h2F)) ||
               (a == 6'h31) || (a == 6'h38);
    endfunction

    function automatic logic [7:0] reg_reset_val(input int a);
        return (a == 'h2C) ? 8'h0A : 8'h00;
    endfunction

    // ---------------- input synchronizers ----------------
    logic [SYNC_N-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_N-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_N-1:0] mosi_sync_q, mosi_sync_d;
    logic              sclk_prev_q, sclk_prev_d;
    logic              cs_prev_q,   cs_prev_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_N-2:0], spi_clk};
        cs_sync_d   = {cs_sync_q[SYNC_N-2:0],   CS};
        mosi_sync_d = {mosi_sync_q[SYNC_N-2:0], MOSI};
        sclk_s      = sclk_sync_q[SYNC_N-1];
        cs_s        = cs_sync_q[SYNC_N-1];
        mosi_s      = mosi_sync_q[SYNC_N-1];
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        cs_fall     = ~cs_s & cs_prev_q;
        cs_rise     = cs_s & ~cs_prev_q;
    end

    // CS chain resets low so that a CS held low across reset release is
    // never mistaken for a fresh CS falling edge: WAIT_CS must see it high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '1;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
        end
    end

    // ---------------- transaction state ----------------
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic [5:0]  addr_q, addr_d;
    logic        rw_q, rw_d;
    logic        mb_q, mb_d;
    logic        miso_q, miso_d;
    logic        xfer_q, xfer_d;
    logic        wr_pulse_q, wr_pulse_d;
    logic [5:0]  wr_addr_q, wr_addr_d;
    logic [47:0] snap_q, snap_d;
    logic [7:0]  regs_q [64];
    logic [7:0]  regs_d [64];

    logic [7:0]  rx_shift;
    logic [5:0]  next_addr;
    logic [5:0]  rd_addr;
    logic [7:0]  rd_byte;

    // Read-data mux. During CMD the address comes straight from the byte
    // being completed; during DATA it is the address of the following byte.
    always_comb begin
        rx_shift  = {rx_q[6:0], mosi_s};
        next_addr = mb_q ? (addr_q + 6'd1) : addr_q;
        rd_addr   = (state_q == S_CMD) ? rx_shift[5:0] : next_addr;
        rd_byte   = 8'h00;
        case (rd_addr)
            6'h00:   rd_byte = DEVID;
            6'h32:   rd_byte = snap_q[7:0];
            6'h33:   rd_byte = snap_q[15:8];
            6'h34:   rd_byte = snap_q[23:16];
            6'h35:   rd_byte = snap_q[31:24];
            6'h36:   rd_byte = snap_q[39:32];
            6'h37:   rd_byte = snap_q[47:40];
            default: rd_byte = is_writable(rd_addr) ? regs_q[rd_addr] : 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        mb_d       = mb_q;
        miso_d     = miso_q;
        xfer_d     = xfer_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        snap_d     = snap_q;
        regs_d     = regs_q;

        case (state_q)
            S_WAIT_CS: begin
                miso_d = 1'b0;
                if (cs_s) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = S_CMD;
                    bit_cnt_d = 3'd0;
                    xfer_d    = 1'b1;
                    snap_d    = {z_data, y_data, x_data};
                end
            end

            S_CMD: begin
                miso_d = 1'b0;
                if (cs_rise) begin
                    state_d = S_IDLE;
                    xfer_d  = 1'b0;
                end else if (sclk_rise) begin
                    rx_d      = rx_shift;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rw_d    = rx_shift[7];
                        mb_d    = rx_shift[6];
                        addr_d  = rx_shift[5:0];
                        tx_d    = rx_shift[7] ? rd_byte : 8'h00;
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (cs_rise) begin
                    // Any partial byte is simply dropped here.
                    state_d = S_IDLE;
                    xfer_d  = 1'b0;
                    miso_d  = 1'b0;
                end else begin
                    if (sclk_fall && rw_q) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        rx_d      = rx_shift;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d = next_addr;
                            if (rw_q) begin
                                tx_d = rd_byte;
                            end else if (WRITE_EN && is_writable(addr_q)) begin
                                wr_pulse_d     = 1'b1;
                                wr_addr_d      = addr_q;
                                regs_d[addr_q] = rx_shift;
                            end
                        end
                    end
                end
            end

            default: state_d = S_WAIT_CS;
        endcase
    end

    // Reset lands in WAIT_CS so a transaction already under way when reset
    // is released is ignored until CS returns high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_WAIT_CS;
            bit_cnt_q  <= 3'd0;
            rx_q       <= 8'h00;
            tx_q       <= 8'h00;
            addr_q     <= 6'h00;
            rw_q       <= 1'b0;
            mb_q       <= 1'b0;
            miso_q     <= 1'b0;
            xfer_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= 6'h00;
            snap_q     <= 48'h0;
            for (int i = 0; i < 64; i++) begin
                regs_q[i] <= reg_reset_val(i);
            end
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            mb_q       <= mb_d;
            miso_q     <= miso_d;
            xfer_q     <= xfer_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            snap_q     <= snap_d;
            for (int i = 0; i < 64; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign MISO        = miso_q;
    assign xfer_active = xfer_q;
    assign wr_pulse    = wr_pulse_q;
    assign wr_addr     = wr_addr_q;
    assign power_ctl   = regs_q[6'h2D];
    assign data_format = regs_q[6'h31];
    assign bw_rate     = regs_q[6'h2C];

endmodule

// File: tb/tb_adxl345_spi_responder.sv
`timescale 1ns/1ps
module tb_adxl345_spi_responder;

`ifdef ADXL_RESP_WRITE_EN
    localparam bit WE = 1'b1;
`else
    localparam bit WE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_clk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic [15:0] x_data, y_data, z_data;
    logic [7:0]  power_ctl, data_format, bw_rate;
    logic        wr_pulse;
    logic [5:0]  wr_addr;
    logic        xfer_active;

    adxl345_spi_responder dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .CS(cs_n), .MOSI(mosi), .MISO(miso),
        .x_data(x_data), .y_data(y_data), .z_data(z_data),
        .power_ctl(power_ctl), .data_format(data_format), .bw_rate(bw_rate),
        .wr_pulse(wr_pulse), .wr_addr(wr_addr), .xfer_active(xfer_active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: expected read bytes and expected write-commit addresses.
    logic [7:0] exp_rd_q[$];
    logic [5:0] exp_wr_q[$];

    // Reference model state.
    logic [7:0]  mregs [64];
    logic [15:0] mx, my, mz;
    logic        rd_mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_writable(input int a);
        return (a >= 'h1D && a <= 'h2A) || (a >= 'h2C && a <= 'h2F) || a == 'h31 || a == 'h38;
    endfunction

    function automatic logic [7:0] m_read(input int a);
        int k;
        logic [15:0] v;
        if (a == 0) return 8'hE5;
        if (a >= 'h32 && a <= 'h37) begin
            k = a - 'h32;
            v = (k / 2 == 0) ? mx : ((k / 2 == 1) ? my : mz);
            return (k % 2 == 1) ? v[15:8] : v[7:0];
        end
        if (m_writable(a)) return mregs[a];
        return 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mregs[i] = 8'h00;
        mregs['h2C] = 8'h0A;
        mx = 16'h0; my = 16'h0; mz = 16'h0;
    endtask

    // Read monitor: assembles MISO bits at each SPI rising edge (where the
    // initiator samples) and compares complete bytes with the scoreboard.
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;
    always @(posedge spi_clk) begin
        if (rd_mon_en) begin
            mon_byte = {mon_byte[6:0], miso};
            mon_cnt++;
            if (mon_cnt == 8) begin
                mon_cnt = 0;
                if (exp_rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got byte 0x%0h with no expectation queued", mon_byte);
                end else begin
                    check("rd_byte", {24'h0, mon_byte}, {24'h0, exp_rd_q.pop_front()});
                end
            end
        end
    end

    // Write monitor: every wr_pulse cycle must match one queued commit.
    always @(negedge clk) begin
        if (!rst && wr_pulse === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_pulse_unexpected: got pulse addr 0x%0h required none", wr_addr);
            end else begin
                check("wr_addr", {26'h0, wr_addr}, {26'h0, exp_wr_q.pop_front()});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Half SPI period = 8 clk, i.e. spi_clk = clk/16.
    task automatic spi_bit(input logic b);
        spi_clk = 1'b0;
        mosi    = b;
        wait_clk(8);
        spi_clk = 1'b1;
        wait_clk(8);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_power_ctl"},   {24'h0, power_ctl},   {24'h0, mregs['h2D]});
        check({tag, "_data_format"}, {24'h0, data_format}, {24'h0, mregs['h31]});
        check({tag, "_bw_rate"},     {24'h0, bw_rate},     {24'h0, mregs['h2C]});
    endtask

    // One complete transaction. Data bytes for writes come from wd, byte k
    // in wd[8k+7:8k]. 'partial' extra bits are clocked before CS rises.
    task automatic xfer(input bit rw, input bit mb, input logic [5:0] addr,
                        input int nb, input int partial, input logic [63:0] wd);
        logic [5:0] a;
        logic [7:0] b;
        mx = x_data; my = y_data; mz = z_data;
        cs_n = 1'b0;
        wait_clk(8);
        check("xfer_active_on", {31'h0, xfer_active}, 32'h1);
        // Inputs move after the snapshot; reads must still see the snapshot.
        x_data = 16'($urandom); y_data = 16'($urandom); z_data = 16'($urandom);
        spi_byte({rw, mb, addr});
        a = addr;
        for (int k = 0; k < nb; k++) begin
            b = wd[8*k +: 8];
            if (rw) begin
                exp_rd_q.push_back(m_read(a));
                rd_mon_en = 1'b1;
                spi_byte(8'($urandom));
            end else begin
                if (WE && m_writable(a)) begin
                    exp_wr_q.push_back(a);
                    mregs[a] = b;
                end
                spi_byte(b);
            end
            if (mb) a = a + 6'd1;
        end
        rd_mon_en = 1'b0;
        for (int k = 0; k < partial; k++) spi_bit(1'($urandom));
        wait_clk(8);
        cs_n = 1'b1;
        wait_clk(8);
        check("xfer_active_off", {31'h0, xfer_active}, 32'h0);
        check("miso_idle", {31'h0, miso}, 32'h0);
        check("rd_pending", exp_rd_q.size(), 0);
        check("wr_pending", exp_wr_q.size(), 0);
        check_outputs("post_xfer");
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_miso"},        {31'h0, miso},        32'h0);
        check({tag, "_wr_pulse"},    {31'h0, wr_pulse},    32'h0);
        check({tag, "_wr_addr"},     {26'h0, wr_addr},     32'h0);
        check({tag, "_xfer_active"}, {31'h0, xfer_active}, 32'h0);
        check({tag, "_power_ctl"},   {24'h0, power_ctl},   32'h00);
        check({tag, "_data_format"}, {24'h0, data_format}, 32'h00);
        check({tag, "_bw_rate"},     {24'h0, bw_rate},     32'h0A);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         rw, mb;
        logic [5:0] ad;
        int         nb, pb;
        rst = 1'b1; cs_n = 1'b1; spi_clk = 1'b1; mosi = 1'b0;
        x_data = 16'h0; y_data = 16'h0; z_data = 16'h0;
        model_reset();
        wait_clk(5);
        check_reset_state("reset");
        rst = 1'b0;
        wait_clk(8);

        // Device ID.
        xfer(1'b1, 1'b0, 6'h00, 1, 0, 64'h0);
        // Multi-byte snapshot read.
        x_data = 16'h1234; y_data = 16'hABCD; z_data = 16'hFF01;
        xfer(1'b1, 1'b1, 6'h32, 6, 0, 64'h0);
        // Single write to POWER_CTL, then read back.
        xfer(1'b0, 1'b0, 6'h2D, 1, 0, 64'h08);
        xfer(1'b1, 1'b0, 6'h2D, 1, 0, 64'h0);
        // Multi-byte write 0x2D..0x2F, read back; write to 0x00 is ignored.
        xfer(1'b0, 1'b1, 6'h2D, 3, 0, 64'h550B08);
        xfer(1'b1, 1'b1, 6'h2D, 3, 0, 64'h0);
        xfer(1'b0, 1'b0, 6'h00, 1, 0, 64'h77);
        xfer(1'b1, 1'b0, 6'h00, 1, 0, 64'h0);
        // MB=0 repeats the address; MB=1 wraps 0x3F -> 0x00.
        xfer(1'b1, 1'b0, 6'h33, 3, 0, 64'h0);
        xfer(1'b1, 1'b1, 6'h3E, 4, 0, 64'h0);
        // Partial byte write to DATA_FORMAT is discarded.
        xfer(1'b0, 1'b0, 6'h31, 0, 5, 64'hFF);
        xfer(1'b1, 1'b0, 6'h31, 1, 0, 64'h0);
        // Full byte then partial byte: only the first commits.
        xfer(1'b0, 1'b1, 6'h2C, 1, 3, 64'h0F);
        xfer(1'b1, 1'b1, 6'h2C, 2, 0, 64'h0);

        // Randomized transactions.
        for (int t = 0; t < 16; t++) begin
            rw = 1'($urandom);
            mb = 1'($urandom);
            ad = ($urandom % 2 == 0) ? 6'($urandom) : 6'(6'h2A + ($urandom % 16));
            nb = 1 + ($urandom % 4);
            pb = ($urandom % 4 == 0) ? int'($urandom % 8) : 0;
            x_data = 16'($urandom); y_data = 16'($urandom); z_data = 16'($urandom);
            xfer(rw, mb, ad, nb, pb, {$urandom, $urandom});
        end

        // Reset in the middle of a read with CS held low.
        x_data = 16'hC0DE; y_data = 16'hBEEF; z_data = 16'h5A5A;
        mx = x_data; my = y_data; mz = z_data;
        cs_n = 1'b0;
        wait_clk(8);
        spi_byte(8'hF2);
        exp_rd_q.push_back(m_read('h32));
        rd_mon_en = 1'b1;
        spi_byte(8'h00);
        rd_mon_en = 1'b0;
        rst = 1'b1;
        wait_clk(3);
        model_reset();
        check_reset_state("midreset");
        rst = 1'b0;
        wait_clk(4);
        // CS still low: this traffic must be ignored.
        spi_byte(8'h80);
        check("ignored_xfer_active", {31'h0, xfer_active}, 32'h0);
        check("ignored_miso_a", {31'h0, miso}, 32'h0);
        spi_byte(8'h00);
        check("ignored_miso_b", {31'h0, miso}, 32'h0);
        cs_n = 1'b1;
        wait_clk(8);
        check("ignored_xfer_done", {31'h0, xfer_active}, 32'h0);
        check_outputs("after_midreset");
        xfer(1'b1, 1'b0, 6'h00, 1, 0, 64'h0);

        check("final_rd_queue", exp_rd_q.size(), 0);
        check("final_wr_queue", exp_wr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
